// File: rtl/hcsr04_scan_scheduler_if.sv
// Result stream from the scan scheduler to the distance consumer (display/UART).
interface hcsr04_scan_scheduler_if #(
  parameter int unsigned IDW    = 2,
  parameter int unsigned DIST_W = 12
);
  logic              out_valid;
  logic              out_ready;
  logic [IDW-1:0]    out_id;
  logic [DIST_W-1:0] out_dist;
  logic              out_timeout;

  modport master (
    output out_valid, out_id, out_dist, out_timeout,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_id, out_dist, out_timeout,
    output out_ready
  );
endinterface

// File: rtl/hcsr04_scan_scheduler.sv
// Round-robin trigger scheduler for HCSR04 rangers sharing one acoustic space:
// fire one sensor, wait for echo or timeout, publish, then hold a quiet gap.
module hcsr04_scan_scheduler #(
  parameter int unsigned N_SENS      = 4,
  parameter int unsigned DIST_W      = 12,
  parameter int unsigned TIMEOUT_CYC = 3_000_000,
  parameter int unsigned GAP_CYC     = 6_000_000,
  parameter int unsigned IDW         = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_SENS-1:0]          en_mask,
  output logic [N_SENS-1:0]          start_o,
  input  logic [N_SENS-1:0]          val_i,
  input  logic [N_SENS*DIST_W-1:0]   dist_i,
  hcsr04_scan_scheduler_if.master    out_if,
  output logic                       busy
);

  localparam int unsigned MAXC = (TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_WAIT,
    ST_PUBLISH,
    ST_GAP
  } state_t;

  state_t              state_q;
  logic [IDW-1:0]      idx_q;
  logic [CW-1:0]       cnt_q;
  logic [N_SENS-1:0]   start_q;
  logic                valid_q;
  logic [IDW-1:0]      id_q;
  logic [DIST_W-1:0]   dist_q;
  logic                timeout_q;
  logic                busy_q;

  logic [IDW-1:0]      idx_first_d;
  logic [IDW-1:0]      idx_next_d;
  logic [IDW-1:0]      fire_idx_d;
  logic [N_SENS-1:0]   fire_oh_d;
  logic                found_first;
  logic                found_next;
  int unsigned         j_first;
  int unsigned         j_next;
  logic [DIST_W-1:0]   dist_a [N_SENS];

  for (genvar g = 0; g < N_SENS; g++) begin : g_unpack
    assign dist_a[g] = dist_i[g*DIST_W +: DIST_W];
  end

  // Rotating priority search: "first" includes idx itself, "next" starts one past it
  // and only lands back on idx after a full wrap.
  always_comb begin
    idx_first_d = idx_q;
    idx_next_d  = idx_q;
    found_first = 1'b0;
    found_next  = 1'b0;
    j_first     = 0;
    j_next      = 0;
    for (int unsigned k = 0; k < N_SENS; k++) begin
      j_first = int'(idx_q) + k;
      if (j_first >= N_SENS) j_first = j_first - N_SENS;
      if (!found_first && en_mask[IDW'(j_first)]) begin
        idx_first_d = IDW'(j_first);
        found_first = 1'b1;
      end
      j_next = int'(idx_q) + k + 1;
      if (j_next >= N_SENS) j_next = j_next - N_SENS;
      if (!found_next && en_mask[IDW'(j_next)]) begin
        idx_next_d = IDW'(j_next);
        found_next = 1'b1;
      end
    end
  end

  always_comb begin
    fire_idx_d            = (state_q == ST_IDLE) ? idx_first_d : idx_q;
    fire_oh_d             = '0;
    fire_oh_d[fire_idx_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      start_q   <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      dist_q    <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      start_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (en && (|en_mask)) begin
            idx_q   <= idx_first_d;
            start_q <= fire_oh_d;
            busy_q  <= 1'b1;
            state_q <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (val_i[idx_q]) begin
            id_q      <= idx_q;
            dist_q    <= dist_a[idx_q];
            timeout_q <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= ST_PUBLISH;
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            id_q      <= idx_q;
            dist_q    <= '1;
            timeout_q <= 1'b1;
            valid_q   <= 1'b1;
            state_q   <= ST_PUBLISH;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_PUBLISH: begin
          if (out_if.out_ready) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= idx_next_d;
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt_q == CW'(GAP_CYC - 1)) begin
            if (en && (|en_mask)) begin
              start_q <= fire_oh_d;
              state_q <= ST_FIRE;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign start_o            = start_q;
  assign busy               = busy_q;
  assign out_if.out_valid   = valid_q;
  assign out_if.out_id      = id_q;
  assign out_if.out_dist    = dist_q;
  assign out_if.out_timeout = timeout_q;

endmodule

// File: tb/tb_hcsr04_scan_scheduler.sv
// Directed bench for hcsr04_scan_scheduler with short timeout/gap so full scans fit in a few thousand cycles.
module tb_hcsr04_scan_scheduler;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        en      = 1'b0;
  logic [3:0]  en_mask = 4'b0000;
  logic [3:0]  start_o;
  logic [3:0]  val_i   = 4'b0000;
  logic [47:0] dist_i  = '0;
  logic        busy;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  hcsr04_scan_scheduler_if #(.IDW(2), .DIST_W(12)) bus ();

  hcsr04_scan_scheduler #(
    .N_SENS      (4),
    .DIST_W      (12),
    .TIMEOUT_CYC (100),
    .GAP_CYC     (20),
    .IDW         (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .en_mask (en_mask),
    .start_o (start_o),
    .val_i   (val_i),
    .dist_i  (dist_i),
    .out_if  (bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until a start pulse appears; n is the number of cycles after the current one.
  task automatic wait_start(output int n, input int bound);
    n = 0;
    do begin
      tick();
      n++;
    end while (start_o === 4'b0000 && n < bound);
  endtask

  // Sensor model: quiet for dly cycles after the start pulse, then one-cycle val with distance d.
  task automatic respond(input logic [1:0] s, input int dly, input logic [11:0] d);
    int bad;
    bad = 0;
    for (int k = 0; k < dly; k++) begin
      tick();
      if (bus.out_valid !== 1'b0 || start_o !== 4'b0000) bad++;
    end
    case (s)
      2'd0: dist_i[11:0]  = d;
      2'd1: dist_i[23:12] = d;
      2'd2: dist_i[35:24] = d;
      default: dist_i[47:36] = d;
    endcase
    val_i[s] = 1'b1;
    tick();
    val_i = 4'b0000;
    chk("respond_quiet", 32'(bad), 32'd0);
  endtask

  initial begin
    int n;
    int bad;
    bus.out_ready = 1'b1;

    repeat (3) tick();
    chk("rst_start",   32'(start_o),         32'd0);
    chk("rst_valid",   32'(bus.out_valid),   32'd0);
    chk("rst_id",      32'(bus.out_id),      32'd0);
    chk("rst_dist",    32'(bus.out_dist),    32'd0);
    chk("rst_timeout", 32'(bus.out_timeout), 32'd0);
    chk("rst_busy",    32'(busy),            32'd0);

    rst = 1'b1;
    tick();
    chk("idle_start", 32'(start_o), 32'd0);
    chk("idle_busy",  32'(busy),    32'd0);

    en = 1'b1;
    en_mask = 4'b1111;
    tick();
    chk("first_start", 32'(start_o), 32'b0001);
    chk("fire_busy",   32'(busy),    32'd1);

    respond(2'd0, 30, 12'd85);
    chk("s0_valid",   32'(bus.out_valid),   32'd1);
    chk("s0_id",      32'(bus.out_id),      32'd0);
    chk("s0_dist",    32'(bus.out_dist),    32'd85);
    chk("s0_timeout", 32'(bus.out_timeout), 32'd0);
    wait_start(n, 200);
    chk("s0_gap",   32'(n),       32'd21);
    chk("s1_start", 32'(start_o), 32'b0010);

    // Sensor 1 silent; a stray val on the other sensors mid-wait must be ignored.
    n = 0;
    do begin
      tick();
      n++;
      val_i = (n == 20) ? 4'b1101 : 4'b0000;
    end while (bus.out_valid !== 1'b1 && n < 300);
    val_i = 4'b0000;
    chk("s1_to_latency", 32'(n),               32'd101);
    chk("s1_id",         32'(bus.out_id),      32'd1);
    chk("s1_dist",       32'(bus.out_dist),    32'hFFF);
    chk("s1_timeout",    32'(bus.out_timeout), 32'd1);
    wait_start(n, 200);
    chk("s1_gap",   32'(n),       32'd21);
    chk("s2_start", 32'(start_o), 32'b0100);

    respond(2'd2, 10, 12'd300);
    chk("s2_valid", 32'(bus.out_valid), 32'd1);
    chk("s2_id",    32'(bus.out_id),    32'd2);
    chk("s2_dist",  32'(bus.out_dist),  32'd300);
    wait_start(n, 200);
    chk("s2_gap",   32'(n),       32'd21);
    chk("s3_start", 32'(start_o), 32'b1000);

    en_mask = 4'b1010;
    respond(2'd3, 40, 12'd1234);
    chk("s3_id",   32'(bus.out_id),   32'd3);
    chk("s3_dist", 32'(bus.out_dist), 32'd1234);
    wait_start(n, 200);
    chk("m_gap0",   32'(n),       32'd21);
    chk("m_start0", 32'(start_o), 32'b0010);

    bus.out_ready = 1'b0;
    respond(2'd1, 7, 12'd55);
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_id",    32'(bus.out_id),    32'd1);
    bad = 0;
    repeat (50) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1 || bus.out_dist !== 12'd55 ||
          bus.out_timeout !== 1'b0 || start_o !== 4'b0000) bad++;
    end
    chk("stall_stable", 32'(bad), 32'd0);
    bus.out_ready = 1'b1;
    wait_start(n, 200);
    chk("stall_gap", 32'(n),       32'd21);
    chk("m_start1",  32'(start_o), 32'b1000);

    respond(2'd3, 3, 12'd77);
    chk("m_s3_dist", 32'(bus.out_dist), 32'd77);
    wait_start(n, 200);
    chk("m_gap2",   32'(n),       32'd21);
    chk("m_start2", 32'(start_o), 32'b0010);

    // val arrives on the timeout terminal-count cycle.
    respond(2'd1, 100, 12'd999);
    chk("tc_valid",   32'(bus.out_valid),   32'd1);
    chk("tc_timeout", 32'(bus.out_timeout), 32'd0);
    chk("tc_dist",    32'(bus.out_dist),    32'd999);
    wait_start(n, 200);
    chk("tc_gap",   32'(n),       32'd21);
    chk("tc_start", 32'(start_o), 32'b1000);

    en = 1'b0;
    respond(2'd3, 20, 12'd444);
    chk("endrop_valid", 32'(bus.out_valid), 32'd1);
    chk("endrop_dist",  32'(bus.out_dist),  32'd444);
    chk("endrop_busy",  32'(busy),          32'd1);
    bad = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (start_o !== 4'b0000) bad++;
    end while (busy !== 1'b0 && n < 200);
    chk("endrop_idle_lat", 32'(n),   32'd21);
    chk("endrop_nostart",  32'(bad), 32'd0);
    repeat (5) tick();
    chk("idle_hold", 32'(start_o), 32'd0);

    en = 1'b1;
    tick();
    chk("resume_start", 32'(start_o), 32'b0010);
    rst = 1'b0;
    #1;
    chk("async_rst_start", 32'(start_o),       32'd0);
    chk("async_rst_busy",  32'(busy),          32'd0);
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    en_mask = 4'b1111;
    #3;
    rst = 1'b1;
    tick();
    chk("post_rst_start", 32'(start_o), 32'b0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
